// File: rtl/maxnet_pkg.sv
// Shared types and default sizing for the Maxnet winner-take-all controller.
package maxnet_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    ITER,
    RESULT
  } state_t;

  localparam int RES_W_DEF    = 32;
  localparam int CNT_W_DEF    = 5;
  localparam int MAX_ITER_DEF = 31;

endpackage

// File: rtl/maxnet_iter_counter.sv
// Feedback-iteration counter with synchronous clear and a terminal-count flag at MAX_ITER.
module maxnet_iter_counter
  import maxnet_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int MAX_ITER = MAX_ITER_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == CNT_W'(MAX_ITER));

endmodule

// File: rtl/maxnet_controller.sv
// Sequencer for the four-neuron Maxnet datapath: load, iterate until one survivor or the
// iteration limit, then offer the result on a valid/ready handshake.
// Optional `abort` input is enabled by defining MAXNET_CTRL_ABORT_EN.
module maxnet_controller
  import maxnet_pkg::*;
#(
  parameter int RES_W    = RES_W_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int MAX_ITER = MAX_ITER_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             ld_t,
  output logic             sel_t,
  input  logic             dp_done,
  input  logic [RES_W-1:0] dp_max,
  output logic             res_valid,
  input  logic             res_ready,
`ifdef MAXNET_CTRL_ABORT_EN
  input  logic             abort,
`endif
  output logic [RES_W-1:0] res_data,
  output logic [CNT_W-1:0] res_iters,
  output logic             res_timeout
);

  state_t state, next;
  logic [CNT_W-1:0] count;
  logic tc, inc, capture, timeout_next;

  maxnet_iter_counter #(
    .CNT_W   (CNT_W),
    .MAX_ITER(MAX_ITER)
  ) u_counter (
    .clk  (clk),
    .rst  (rst),
    .clear(state == IDLE),
    .inc  (inc),
    .count(count),
    .tc   (tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next;
    end
  end

  // In ITER a survivor wins over the limit, and neither case loads again.
  always_comb begin
    next         = state;
    ld_t         = 1'b0;
    sel_t        = 1'b0;
    inc          = 1'b0;
    capture      = 1'b0;
    timeout_next = 1'b0;
    case (state)
      IDLE: begin
        if (start) next = LOAD;
      end
      LOAD: begin
        ld_t  = 1'b1;
        sel_t = 1'b1;
        next  = CHECK;
      end
      CHECK: begin
        if (dp_done) begin
          capture = 1'b1;
          next    = RESULT;
        end else begin
          next = ITER;
        end
      end
      ITER: begin
        if (dp_done) begin
          capture = 1'b1;
          next    = RESULT;
        end else if (tc) begin
          capture      = 1'b1;
          timeout_next = 1'b1;
          next         = RESULT;
        end else begin
          ld_t = 1'b1;
          inc  = 1'b1;
        end
      end
      RESULT: begin
        if (res_ready) next = IDLE;
      end
      default: next = IDLE;
    endcase
`ifdef MAXNET_CTRL_ABORT_EN
    if (abort && (state == LOAD || state == CHECK || state == ITER)) begin
      next    = IDLE;
      ld_t    = 1'b0;
      inc     = 1'b0;
      capture = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_data    <= '0;
      res_iters   <= '0;
      res_timeout <= 1'b0;
    end else if (capture) begin
      res_data    <= dp_max;
      res_iters   <= count;
      res_timeout <= timeout_next;
    end
  end

  assign busy      = (state != IDLE);
  assign res_valid = (state == RESULT);

endmodule
